// File: rtl/spk_in_mp.sv
// spk_in_mp: multi-port spike input block.
// Each router port feeds its own FIFO. The FIFO heads are arbitrated round-robin,
// and the winner is routed to the axon unit or the config unit, or it is discarded.
// Config traffic is flow-controlled by a small credit counter.
module spk_in_mp #(
    parameter int NP       = 4,
    parameter int B        = 4,
    parameter int FW       = 59,
    parameter int FTW      = 3,
    parameter int SW       = 24,
    parameter int CFG_CRED = 2,
    parameter int PW       = 2
) (
    input  logic             clk_spk_in,
    input  logic             rst_n,
    input  logic [NP*FW-1:0] flit_in,
    input  logic [NP-1:0]    flit_in_wr,
    output logic [NP-1:0]    credit_out,
    input  logic             config_spk_in_credit,
    output logic             spk_in_config_we,
    output logic [FW-1:0]    spk_in_config_wdata,
    input  logic             axon_busy,
    output logic             spk_in_axon_vld,
    output logic [SW-1:0]    spk_in_axon_data,
    output logic [FTW-1:0]   spk_in_axon_type,
    output logic [PW-1:0]    spk_in_axon_port,
    output logic [7:0]       drop_cnt
);
    localparam int DEPTH = 1 << B;
    localparam int CW    = $clog2(CFG_CRED + 1);
    localparam logic [CW-1:0] CRED_MAX = CW'(CFG_CRED);

    logic [NP-1:0][FW-1:0] head;
    logic [NP-1:0]         head_vld;
    logic [NP-1:0]         drop;
    logic [NP-1:0]         eligible;
    logic [NP-1:0]         pop;
    logic                  grant_vld;
    logic [PW-1:0]         grant_idx;
    logic [FW-1:0]         grant_flit;
    logic [FTW-1:0]        grant_type;
    logic                  grant_axon;
    logic                  grant_cfg;
    logic                  grant_disc;
    logic [CW-1:0]         cred;
    logic [PW-1:0]         rr_ptr;
    logic [7:0]            drop_cnt_next;

    // SPIKE / DATA / DATA_END go to the axon.
    function automatic logic is_axon(input logic [FTW-1:0] t);
        return (t == FTW'(0)) || (t == FTW'(1)) || (t == FTW'(2));
    endfunction

    // WRITE / READ go to config. Everything else is discarded.
    function automatic logic is_cfg(input logic [FTW-1:0] t);
        return (t == FTW'(6)) || (t == FTW'(7));
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NP; gi++) begin : g_port
            logic [FW-1:0]  mem [DEPTH];
            logic [B:0]     wr_ptr;
            logic [B:0]     rd_ptr;
            logic           full;
            logic           wr_ok;
            logic [FTW-1:0] htype;

            assign full   = (wr_ptr[B] != rd_ptr[B]) && (wr_ptr[B-1:0] == rd_ptr[B-1:0]);
            // A full FIFO still accepts a write when its head is popped in the same cycle.
            assign wr_ok  = flit_in_wr[gi] && (!full || pop[gi]);
            assign drop[gi]     = flit_in_wr[gi] && !wr_ok;
            assign head_vld[gi] = (wr_ptr != rd_ptr);
            assign head[gi]     = mem[rd_ptr[B-1:0]];
            assign htype        = head[gi][FW-1 -: FTW];
            // An ineligible head only stalls its own port.
            assign eligible[gi] = head_vld[gi] &&
                                  (is_axon(htype) ? !axon_busy :
                                   (is_cfg(htype) ? (cred != '0) : 1'b1));

            // FIFO storage write. There is no bypass, so a new flit reaches the head one cycle later.
            always_ff @(posedge clk_spk_in) begin
                if (wr_ok)
                    mem[wr_ptr[B-1:0]] <= flit_in[gi*FW +: FW];
            end

            // FIFO pointers. Reset empties the FIFO.
            always_ff @(posedge clk_spk_in or negedge rst_n) begin
                if (!rst_n) begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                end else begin
                    if (wr_ok)
                        wr_ptr <= wr_ptr + 1'b1;
                    if (pop[gi])
                        rd_ptr <= rd_ptr + 1'b1;
                end
            end
        end
    endgenerate

    // Round-robin scan: the grant goes to the first eligible head at or after rr_ptr.
    always_comb begin
        int            sum_i;
        logic [PW-1:0] idx;
        grant_vld = 1'b0;
        grant_idx = '0;
        sum_i     = 0;
        idx       = '0;
        for (int i = 0; i < NP; i++) begin
            sum_i = int'(rr_ptr) + i;
            if (sum_i >= NP)
                sum_i = sum_i - NP;
            idx = PW'(sum_i);
            if (!grant_vld && eligible[idx]) begin
                grant_vld = 1'b1;
                grant_idx = idx;
            end
        end
    end

    // Decode the granted head. The pop and credit pulse happen in the grant cycle.
    always_comb begin
        pop = '0;
        if (grant_vld)
            pop[grant_idx] = 1'b1;
        grant_flit = head[grant_idx];
        grant_type = grant_flit[FW-1 -: FTW];
        grant_axon = grant_vld && is_axon(grant_type);
        grant_cfg  = grant_vld && is_cfg(grant_type);
        grant_disc = grant_vld && !is_axon(grant_type) && !is_cfg(grant_type);
    end

    assign credit_out = pop;

    // Drop counter next value. It sums every port overflow plus any discard, and saturates at 255.
    always_comb begin
        int sum;
        sum = int'(drop_cnt) + $countones(drop) + (grant_disc ? 1 : 0);
        drop_cnt_next = (sum > 255) ? 8'd255 : 8'(sum);
    end

    // Round-robin pointer moves past the last granted port.
    always_ff @(posedge clk_spk_in or negedge rst_n) begin
        if (!rst_n)
            rr_ptr <= '0;
        else if (grant_vld)
            rr_ptr <= (int'(grant_idx) == NP - 1) ? '0 : grant_idx + 1'b1;
    end

    // Config credit is taken at grant, so a second config grant cannot overdraw it.
    always_ff @(posedge clk_spk_in or negedge rst_n) begin
        if (!rst_n)
            cred <= CRED_MAX;
        else if (grant_cfg && !config_spk_in_credit)
            cred <= cred - 1'b1;
        else if (!grant_cfg && config_spk_in_credit && cred != CRED_MAX)
            cred <= cred + 1'b1;
    end

    // Output registers. Strobes last one cycle, and payload fields hold their values between loads.
    always_ff @(posedge clk_spk_in or negedge rst_n) begin
        if (!rst_n) begin
            spk_in_axon_vld     <= 1'b0;
            spk_in_axon_data    <= '0;
            spk_in_axon_type    <= '0;
            spk_in_axon_port    <= '0;
            spk_in_config_we    <= 1'b0;
            spk_in_config_wdata <= '0;
            drop_cnt            <= '0;
        end else begin
            spk_in_axon_vld  <= grant_axon;
            spk_in_config_we <= grant_cfg;
            drop_cnt         <= drop_cnt_next;
            if (grant_axon) begin
                spk_in_axon_data <= grant_flit[SW-1:0];
                spk_in_axon_type <= grant_type;
                spk_in_axon_port <= grant_idx;
            end
            if (grant_cfg)
                spk_in_config_wdata <= grant_flit;
        end
    end
endmodule

// File: tb/tb_spk_in_mp.sv
// Testbench for spk_in_mp.
// A queue-based reference model predicts the credit pulses, strobes, payloads and drop count.
module tb_spk_in_mp;
    localparam int NP = 4, B = 4, FW = 59, FTW = 3, SW = 24, CFG_CRED = 2, PW = 2;
    localparam int DEPTH = 1 << B;
    localparam int BW = NP + 1 + 1 + SW + FTW + PW + FW + 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NP*FW-1:0] flit_in = '0;
    logic [NP-1:0]    flit_in_wr = '0;
    logic             cfg_ret = 1'b0;
    logic             axon_busy = 1'b0;
    logic [NP-1:0]    credit_out;
    logic             cfg_we;
    logic [FW-1:0]    cfg_wdata;
    logic             axon_vld;
    logic [SW-1:0]    axon_data;
    logic [FTW-1:0]   axon_type;
    logic [PW-1:0]    axon_port;
    logic [7:0]       drop_cnt;

    always #5 clk = ~clk;

    spk_in_mp #(.NP(NP), .B(B), .FW(FW), .FTW(FTW), .SW(SW), .CFG_CRED(CFG_CRED), .PW(PW)) dut (
        .clk_spk_in          (clk),
        .rst_n               (rst_n),
        .flit_in             (flit_in),
        .flit_in_wr          (flit_in_wr),
        .credit_out          (credit_out),
        .config_spk_in_credit(cfg_ret),
        .spk_in_config_we    (cfg_we),
        .spk_in_config_wdata (cfg_wdata),
        .axon_busy           (axon_busy),
        .spk_in_axon_vld     (axon_vld),
        .spk_in_axon_data    (axon_data),
        .spk_in_axon_type    (axon_type),
        .spk_in_axon_port    (axon_port),
        .drop_cnt            (drop_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [FW-1:0]  mq [NP][$];
    int             m_cred, m_rr, m_drop, m_grant;
    logic           m_vld, m_we;
    logic [SW-1:0]  m_data;
    logic [FTW-1:0] m_type;
    logic [PW-1:0]  m_port;
    logic [FW-1:0]  m_wdata;
    logic [NP-1:0]  exp_credit, obs_credit;
    logic [BW-1:0]  exp_b, obs_b;

    function automatic logic [FW-1:0] mk(input int t, input logic [SW-1:0] pay);
        logic [FW-1:0] f;
        f = FW'({$urandom(), $urandom()});
        f[FW-1 -: FTW] = t[FTW-1:0];
        f[SW-1:0] = pay;
        return f;
    endfunction

    task automatic model_reset();
        for (int p = 0; p < NP; p++) mq[p].delete();
        m_cred = CFG_CRED; m_rr = 0; m_drop = 0; m_grant = -1;
        m_vld = 0; m_we = 0; m_data = '0; m_type = '0; m_port = '0; m_wdata = '0;
    endtask

    task automatic clear_inputs();
        flit_in_wr = '0;
        cfg_ret = 1'b0;
    endtask

    task automatic put(input int p, input logic [FW-1:0] f);
        flit_in[p*FW +: FW] = f;
        flit_in_wr[p] = 1'b1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        axon_busy = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Runs one cycle from negedge to negedge with the inputs already applied.
    // It records the credit pulse seen in this cycle and the registered outputs that follow it.
    task automatic tick();
        int t, add, g;
        bit el;
        logic [FW-1:0] hf;
        #1;
        m_grant = -1;
        for (int i = 0; i < NP; i++) begin
            int p;
            p = (m_rr + i) % NP;
            if (m_grant < 0 && mq[p].size() > 0) begin
                hf = mq[p][0];
                t = int'(hf[FW-1 -: FTW]);
                if (t <= 2) el = !axon_busy;
                else if (t >= 6) el = (m_cred > 0);
                else el = 1'b1;
                if (el) m_grant = p;
            end
        end
        exp_credit = '0;
        if (m_grant >= 0) exp_credit[m_grant] = 1'b1;
        obs_credit = credit_out;
        @(posedge clk);
        #1;
        add = 0; m_vld = 0; m_we = 0;
        g = m_grant;
        if (g >= 0) begin
            hf = mq[g].pop_front();
            t = int'(hf[FW-1 -: FTW]);
            if (t <= 2) begin
                m_vld = 1; m_data = hf[SW-1:0]; m_type = FTW'(t); m_port = PW'(g);
            end else if (t >= 6) begin
                m_we = 1; m_wdata = hf; m_cred = m_cred - 1;
            end else add++;
            m_rr = (g + 1) % NP;
        end
        for (int p = 0; p < NP; p++)
            if (flit_in_wr[p]) begin
                if (mq[p].size() < DEPTH) mq[p].push_back(flit_in[p*FW +: FW]);
                else add++;
            end
        if (cfg_ret && m_cred < CFG_CRED) m_cred++;
        m_drop = (m_drop + add > 255) ? 255 : m_drop + add;
        @(negedge clk);
        exp_b = {exp_credit, m_vld, m_we, m_data, m_type, m_port, m_wdata, 8'(m_drop)};
        obs_b = {obs_credit, axon_vld, cfg_we, axon_data, axon_type, axon_port, cfg_wdata, drop_cnt};
    endtask

    task automatic test_reset();
        logic [BW-1:0] o;
        apply_reset();
        #1;
        o = {credit_out, axon_vld, cfg_we, axon_data, axon_type, axon_port, cfg_wdata, drop_cnt};
        n_checks++;
        if (o !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", o); end
        tick();
        n_checks++;
        if (obs_b !== exp_b) begin n_fail++; $display("FAIL reset_idle: got %h want %h", obs_b, exp_b); end
    endtask

    task automatic test_single();
        apply_reset();
        put(0, mk(0, 24'hABCDEF));
        tick();
        clear_inputs();
        n_checks++;
        if (obs_b !== exp_b) begin n_fail++; $display("FAIL single_t0: got %h want %h", obs_b, exp_b); end
        tick();
        n_checks++;
        if (obs_credit !== 4'b0001) begin n_fail++; $display("FAIL single_credit: got %b want 0001", obs_credit); end
        n_checks++;
        if ({axon_vld, axon_data, axon_type, axon_port} !== {1'b1, 24'hABCDEF, 3'd0, 2'd0}) begin
            n_fail++; $display("FAIL single_out: got vld=%b data=%h type=%0d port=%0d want 1 abcdef 0 0",
                               axon_vld, axon_data, axon_type, axon_port);
        end
        tick();
        n_checks++;
        if (axon_vld !== 1'b0 || axon_data !== 24'hABCDEF) begin
            n_fail++; $display("FAIL single_hold: got vld=%b data=%h want 0 abcdef", axon_vld, axon_data);
        end
    endtask

    task automatic test_all_ports();
        apply_reset();
        for (int p = 0; p < NP; p++) put(p, mk(0, SW'(p + 1)));
        tick();
        clear_inputs();
        for (int k = 0; k < NP; k++) begin
            tick();
            n_checks++;
            if (obs_b !== exp_b) begin n_fail++; $display("FAIL all_ports_model c%0d: got %h want %h", k, obs_b, exp_b); end
            n_checks++;
            if (obs_credit !== NP'(1 << k) || axon_vld !== 1'b1 || axon_port !== PW'(k) || axon_data !== SW'(k + 1)) begin
                n_fail++; $display("FAIL all_ports_order c%0d: got credit=%b vld=%b port=%0d data=%h want credit=%b vld=1 port=%0d",
                                   k, obs_credit, axon_vld, axon_port, axon_data, NP'(1 << k), k);
            end
        end
        tick();
        n_checks++;
        if (axon_vld !== 1'b0) begin n_fail++; $display("FAIL all_ports_end: got vld=%b want 0", axon_vld); end
    endtask

    task automatic test_config_credit();
        int nwe;
        apply_reset();
        nwe = 0;
        for (int c = 0; c < 8; c++) begin
            clear_inputs();
            if (c < 3) put(1, mk(6, SW'(c)));
            tick();
            if (cfg_we) nwe++;
            n_checks++;
            if (obs_b !== exp_b) begin n_fail++; $display("FAIL cfg_model c%0d: got %h want %h", c, obs_b, exp_b); end
        end
        n_checks++;
        if (nwe !== 2) begin n_fail++; $display("FAIL cfg_two_we: got %0d want 2", nwe); end
        clear_inputs();
        cfg_ret = 1'b1;
        tick();
        cfg_ret = 1'b0;
        nwe = 0;
        for (int c = 0; c < 2; c++) begin
            tick();
            if (cfg_we) nwe++;
            n_checks++;
            if (obs_b !== exp_b) begin n_fail++; $display("FAIL cfg_ret_model c%0d: got %h want %h", c, obs_b, exp_b); end
        end
        n_checks++;
        if (nwe !== 1) begin n_fail++; $display("FAIL cfg_third_we: got %0d want 1", nwe); end
    endtask

    task automatic test_busy_bypass();
        apply_reset();
        axon_busy = 1'b1;
        put(0, mk(0, 24'h000111));
        put(2, mk(7, 24'h000222));
        tick();
        clear_inputs();
        tick();
        n_checks++;
        if (obs_credit !== 4'b0100 || cfg_we !== 1'b1 || axon_vld !== 1'b0) begin
            n_fail++; $display("FAIL busy_read: got credit=%b we=%b vld=%b want 0100 1 0", obs_credit, cfg_we, axon_vld);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if (obs_b !== exp_b) begin n_fail++; $display("FAIL busy_wait c%0d: got %h want %h", c, obs_b, exp_b); end
        end
        axon_busy = 1'b0;
        tick();
        n_checks++;
        if (obs_credit !== 4'b0001 || axon_vld !== 1'b1 || axon_data !== 24'h000111) begin
            n_fail++; $display("FAIL busy_release: got credit=%b vld=%b data=%h want 0001 1 000111", obs_credit, axon_vld, axon_data);
        end
    endtask

    task automatic test_overflow_discard();
        apply_reset();
        axon_busy = 1'b1;
        for (int c = 0; c < 17; c++) begin
            clear_inputs();
            put(3, mk(0, SW'(c)));
            tick();
        end
        clear_inputs();
        tick();
        n_checks++;
        if (drop_cnt !== 8'd1 || mq[3].size() != 16) begin
            n_fail++; $display("FAIL overflow_drop: got drop=%0d want 1", drop_cnt);
        end
        put(0, mk(4, 24'h0000AA));
        tick();
        clear_inputs();
        tick();
        n_checks++;
        if (obs_credit !== 4'b0001 || axon_vld !== 1'b0 || cfg_we !== 1'b0) begin
            n_fail++; $display("FAIL discard_pop: got credit=%b vld=%b we=%b want 0001 0 0", obs_credit, axon_vld, cfg_we);
        end
        n_checks++;
        if (drop_cnt !== 8'd2) begin n_fail++; $display("FAIL discard_count: got %0d want 2", drop_cnt); end
        n_checks++;
        if (obs_b !== exp_b) begin n_fail++; $display("FAIL discard_model: got %h want %h", obs_b, exp_b); end
    endtask

    task automatic test_saturate();
        apply_reset();
        axon_busy = 1'b1;
        for (int c = 0; c < 84; c++) begin
            for (int p = 0; p < NP; p++) put(p, mk(1, SW'(c)));
            tick();
            n_checks++;
            if (obs_b !== exp_b) begin n_fail++; $display("FAIL saturate_model c%0d: got %h want %h", c, obs_b, exp_b); end
        end
        clear_inputs();
        n_checks++;
        if (drop_cnt !== 8'd255) begin n_fail++; $display("FAIL saturate_255: got %0d want 255", drop_cnt); end
    endtask

    task automatic test_async_reset();
        logic [BW-1:0] o;
        apply_reset();
        axon_busy = 1'b1;
        for (int c = 0; c < 8; c++) begin
            clear_inputs();
            put(1, mk(0, SW'(c + 16)));
            put(2, mk(2, SW'(c + 32)));
            tick();
        end
        axon_busy = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        o = {credit_out, axon_vld, cfg_we, axon_data, axon_type, axon_port, cfg_wdata, drop_cnt};
        n_checks++;
        if (o !== '0) begin n_fail++; $display("FAIL async_reset_outputs: got %h want 0", o); end
        clear_inputs();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_checks++;
            if (obs_b !== exp_b || axon_vld !== 1'b0 || cfg_we !== 1'b0) begin
                n_fail++; $display("FAIL async_reset_idle c%0d: got %h want %h", c, obs_b, exp_b);
            end
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            clear_inputs();
            for (int p = 0; p < NP; p++)
                if ($urandom_range(1, 0) == 1) put(p, mk($urandom_range(7, 0), SW'($urandom())));
            axon_busy = ($urandom_range(9, 0) < 3);
            cfg_ret   = ($urandom_range(9, 0) < 2);
            tick();
            n_checks++;
            if (obs_b !== exp_b) begin n_fail++; $display("FAIL random c%0d: got %h want %h", c, obs_b, exp_b); end
        end
        clear_inputs();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_all_ports();
        test_config_credit();
        test_busy_bypass();
        test_overflow_discard();
        test_saturate();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
